reg_file_mp: RTL and testbench

Parametrised multi-port register file for the RISC-V core: the next generation of the core's 2R1W file. Width, depth and read-port count are configurable. It adds a second write port with fixed priority, optional write-to-read bypass, posedge registered reads with per-port read enable, and a sequential clear engine that zeroes the array after reset or on request. It sits between decode (read addresses) and writeback (write ports), and is also used by the CSR shadow bank.

---
 rtl/reg_file_mp.sv | 120 ++++++++++++
 tb/tb_reg_file_mp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD registered read ports,
// optional write-to-read bypass and a sequential clear engine run after reset or on request.
module reg_file_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    output logic                   clr_busy,
    input  logic                   we0,
    input  logic                   we1,
    input  logic [AW-1:0]          wa0,
    input  logic [AW-1:0]          wa1,
    input  logic [XLEN-1:0]        wd0,
    input  logic [XLEN-1:0]        wd1,
    input  logic [NUM_RD-1:0]      re,
    input  logic [NUM_RD*AW-1:0]   ra,
    output logic [NUM_RD*XLEN-1:0] rd
);

    localparam logic [0:0]    StIdle  = 1'b0;
    localparam logic [0:0]    StClear = 1'b1;
    localparam logic [AW-1:0] PtrLast = AW'(DEPTH - 1);

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            clearing;
    logic            wr0_ok, wr1_ok;
    logic [XLEN-1:0] mem [DEPTH];

    assign clearing = (state_q == StClear);
    assign clr_busy = clearing;

    // Clear engine: walks ptr over every entry once; clr is ignored while already clearing.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            StClear: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == PtrLast) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Accepted writes only; these also qualify bypass so dropped writes never forward.
    assign wr0_ok = we0 && rst_n && !clearing && !(ZERO_REG && (wa0 == '0));
    assign wr1_ok = we1 && rst_n && !clearing && !(ZERO_REG && (wa1 == '0));

    // Port 1 is assigned last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst_n && clearing) begin
            mem[ptr_q] <= '0;
        end else begin
            if (wr0_ok) begin
                mem[wa0] <= wd0;
            end
            if (wr1_ok) begin
                mem[wa1] <= wd1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] lane_d, lane_q;

        assign addr = ra[k*AW +: AW];

        always_comb begin
            lane_d = mem[addr];
            if (clearing || (ZERO_REG && (addr == '0))) begin
                lane_d = '0;
            end else if (BYPASS && wr1_ok && (wa1 == addr)) begin
                lane_d = wd1;
            end else if (BYPASS && wr0_ok && (wa0 == addr)) begin
                lane_d = wd0;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                lane_q <= '0;
            end else if (re[k]) begin
                lane_q <= lane_d;
            end
        end

        assign rd[k*XLEN +: XLEN] = lane_q;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: default instance (A), no-bypass/no-zero-reg instance (B) sharing A's inputs,
// and an 8-deep, 64-bit, 4-read-port instance (C).
module tb_reg_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr, we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  re;
    logic [9:0]  ra;
    logic [63:0] a_rd, b_rd;
    logic        a_busy, b_busy;

    logic         c_rst_n, c_clr, c_we0, c_we1;
    logic [2:0]   c_wa0, c_wa1;
    logic [63:0]  c_wd0, c_wd1;
    logic [3:0]   c_re;
    logic [11:0]  c_ra;
    logic [255:0] c_rd;
    logic         c_busy;

    int total = 0;
    int bad   = 0;

    reg_file_mp u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .clr_busy(a_busy),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .re(re), .ra(ra), .rd(a_rd)
    );

    reg_file_mp #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .clr_busy(b_busy),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .re(re), .ra(ra), .rd(b_rd)
    );

    reg_file_mp #(.DEPTH(8), .XLEN(64), .NUM_RD(4)) u_c (
        .clk(clk), .rst_n(c_rst_n), .clr(c_clr), .clr_busy(c_busy),
        .we0(c_we0), .we1(c_we1), .wa0(c_wa0), .wa1(c_wa1), .wd0(c_wd0), .wd1(c_wd1),
        .re(c_re), .ra(c_ra), .rd(c_rd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reads every entry of A and B in pairs; entry 'hot' is expected to hold hv, others zero.
    task automatic read_all(input string tag, input int hot, input logic [31:0] hv);
        logic [63:0] exp;
        for (int i = 0; i < 32; i += 2) begin
            re  = 2'b11;
            ra  = {5'(i + 1), 5'(i)};
            tick();
            exp = {((i + 1) == hot) ? hv : 32'h0, (i == hot) ? hv : 32'h0};
            chk({tag, "_a"}, a_rd, exp);
            chk({tag, "_b"}, b_rd, exp);
        end
        re = 2'b00;
    endtask

    task automatic fill();
        for (int i = 1; i < 32; i++) begin
            we0 = 1'b1;
            wa0 = 5'(i);
            wd0 = 32'(i);
            tick();
        end
        we0 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; we0 = 1'b0; we1 = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; re = '0; ra = '0;
        c_rst_n = 1'b0; c_clr = 1'b0; c_we0 = 1'b0; c_we1 = 1'b0;
        c_wa0 = '0; c_wa1 = '0; c_wd0 = '0; c_wd1 = '0; c_re = '0; c_ra = '0;

        // Reset and post-reset clear
        repeat (3) tick();
        chk("rst_busy_a", 64'(a_busy), 64'h1);
        chk("rst_rd_a", a_rd, 64'h0);
        chk("rst_rd_b", b_rd, 64'h0);
        chk("rst_busy_c", 64'(c_busy), 64'h1);
        rst_n = 1'b1;
        repeat (31) tick();
        chk("clr31_busy", 64'(a_busy), 64'h1);
        tick();
        chk("clr32_busy", 64'(a_busy), 64'h0);
        chk("clr32_busy_b", 64'(b_busy), 64'h0);
        read_all("init_zero", -1, 32'h0);

        // Basic write then read, and lane hold with re low
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        tick();
        we0 = 1'b0; re = 2'b11; ra = {5'd5, 5'd5};
        tick();
        chk("basic_a", a_rd, 64'hDEADBEEF_DEADBEEF);
        chk("basic_b", b_rd, 64'hDEADBEEF_DEADBEEF);
        re = 2'b01; ra = {5'd5, 5'd0};
        tick();
        chk("hold_a", a_rd, 64'hDEADBEEF_00000000);
        chk("hold_b", b_rd, 64'hDEADBEEF_00000000);

        // Dual write to one address: port 1 wins, bypass only on A
        we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7;
        wd0 = 32'h11111111; wd1 = 32'h22222222; re = 2'b01; ra = {5'd0, 5'd7};
        tick();
        chk("dual_byp_a", a_rd, 64'hDEADBEEF_22222222);
        chk("dual_old_b", b_rd, 64'hDEADBEEF_00000000);
        we0 = 1'b0; we1 = 1'b0;
        tick();
        chk("dual_later_a", a_rd, 64'hDEADBEEF_22222222);
        chk("dual_later_b", b_rd, 64'hDEADBEEF_22222222);

        // Writes to entry 0
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; ra = {5'd0, 5'd0};
        tick();
        chk("zero_now_a", a_rd, 64'hDEADBEEF_00000000);
        chk("zero_now_b", b_rd, 64'hDEADBEEF_00000000);
        we0 = 1'b0;
        tick();
        chk("zero_later_a", a_rd, 64'hDEADBEEF_00000000);
        chk("zero_later_b", b_rd, 64'hDEADBEEF_FFFFFFFF);

        // Independent bypass on both ports
        we0 = 1'b1; we1 = 1'b1; wa0 = 5'd3; wa1 = 5'd4;
        wd0 = 32'h33333333; wd1 = 32'h44444444; re = 2'b11; ra = {5'd4, 5'd3};
        tick();
        chk("byp2_a", a_rd, 64'h44444444_33333333);
        chk("byp2_b", b_rd, 64'h00000000_00000000);
        we0 = 1'b0; we1 = 1'b0;
        tick();
        chk("byp2_later_a", a_rd, 64'h44444444_33333333);
        chk("byp2_later_b", b_rd, 64'h44444444_33333333);

        // Clear request: dropped writes, reads forced to zero, clr ignored while busy
        fill();
        re = 2'b11; ra = {5'd31, 5'd30};
        tick();
        chk("fill_a", a_rd, 64'h0000001F_0000001E);
        chk("fill_b", b_rd, 64'h0000001F_0000001E);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrreq_busy", 64'(a_busy), 64'h1);
        chk("clrreq_rd", a_rd, 64'h0000001F_0000001E);
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hBAD0BAD0;
        tick();
        chk("clr_rd_zero_a", a_rd, 64'h0);
        chk("clr_rd_zero_b", b_rd, 64'h0);
        repeat (4) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (25) tick();
        chk("clrreq31_busy", 64'(a_busy), 64'h1);
        tick();
        chk("clrreq32_busy", 64'(a_busy), 64'h0);
        wa0 = 5'd2; wd0 = 32'h12345678;
        tick();
        we0 = 1'b0;
        read_all("after_clr", 2, 32'h12345678);

        // Reset in the middle of a clear restarts it
        fill();
        re = 2'b11; ra = {5'd31, 5'd30};
        tick();
        re = 2'b00; clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (10) tick();
        chk("mid_hold_rd", a_rd, 64'h0000001F_0000001E);
        chk("mid_busy", 64'(a_busy), 64'h1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_rd_a", a_rd, 64'h0);
        chk("mid_rst_rd_b", b_rd, 64'h0);
        tick();
        rst_n = 1'b1;
        repeat (31) tick();
        chk("mid31_busy", 64'(a_busy), 64'h1);
        tick();
        chk("mid32_busy", 64'(a_busy), 64'h0);
        read_all("after_mid", -1, 32'h0);

        // Wide instance: DEPTH=8, XLEN=64, NUM_RD=4
        c_rst_n = 1'b1;
        repeat (7) tick();
        chk("c_clr7_busy", 64'(c_busy), 64'h1);
        tick();
        chk("c_clr8_busy", 64'(c_busy), 64'h0);
        c_we0 = 1'b1; c_wa0 = 3'd1; c_wd0 = 64'h01234567_89ABCDEF;
        c_we1 = 1'b1; c_wa1 = 3'd6; c_wd1 = 64'hFEDCBA98_76543210;
        tick();
        c_wa0 = 3'd3; c_wd0 = 64'hA5A5A5A5_A5A5A5A5;
        c_wa1 = 3'd3; c_wd1 = 64'h5A5A5A5A_5A5A5A5A;
        c_re = 4'b1111; c_ra = {3'd3, 3'd6, 3'd1, 3'd0};
        tick();
        chk("c_l0_zero", c_rd[0 +: 64], 64'h0);
        chk("c_l1_rd", c_rd[64 +: 64], 64'h01234567_89ABCDEF);
        chk("c_l2_rd", c_rd[128 +: 64], 64'hFEDCBA98_76543210);
        chk("c_l3_byp", c_rd[192 +: 64], 64'h5A5A5A5A_5A5A5A5A);
        c_we1 = 1'b0; c_wa0 = 3'd7; c_wd0 = 64'h0F0F0F0F_0F0F0F0F;
        c_re = 4'b0101; c_ra = {3'd7, 3'd3, 3'd2, 3'd3};
        tick();
        chk("c_l0_mem3", c_rd[0 +: 64], 64'h5A5A5A5A_5A5A5A5A);
        chk("c_l1_hold", c_rd[64 +: 64], 64'h01234567_89ABCDEF);
        chk("c_l2_mem3", c_rd[128 +: 64], 64'h5A5A5A5A_5A5A5A5A);
        chk("c_l3_hold", c_rd[192 +: 64], 64'h5A5A5A5A_5A5A5A5A);
        c_we0 = 1'b0;
        c_re = 4'b1010; c_ra = {3'd7, 3'd0, 3'd2, 3'd0};
        tick();
        chk("c_l1_zero", c_rd[64 +: 64], 64'h0);
        chk("c_l3_mem7", c_rd[192 +: 64], 64'h0F0F0F0F_0F0F0F0F);
        c_clr = 1'b1; c_re = 4'b0000;
        tick();
        c_clr = 1'b0;
        repeat (7) tick();
        chk("c_req7_busy", 64'(c_busy), 64'h1);
        tick();
        chk("c_req8_busy", 64'(c_busy), 64'h0);
        c_re = 4'b1111; c_ra = {3'd7, 3'd6, 3'd3, 3'd1};
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("c_cleared_l%0d", k), c_rd[k*64 +: 64], 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
